// File: rtl/ahb_interconnect_guard_pkg.sv
// Shared types for the AHB3-Lite decoder/response guard.
//   owner_t   : who owns the current data phase (nobody, the built-in default
//               ERROR subordinate, or a real subordinate whose index is kept alongside)
//   state_e   : data-phase FSM state
//   pma_cfg_t : one region descriptor (base/mask) per subordinate
package ahb_interconnect_guard_pkg;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {OWN_NONE, OWN_DEFAULT, OWN_SLAVE} owner_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SLAVE, ST_ERR1, ST_ERR2} state_e;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
  } pma_cfg_t;

  // NONSEQ/SEQ start a real data phase; IDLE/BUSY complete as zero-wait OKAY.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

  // Data-phase state entered when an address phase is accepted for owner o.
  function automatic state_e owner_state(input owner_t o);
    case (o)
      OWN_SLAVE:   return ST_SLAVE;
      OWN_DEFAULT: return ST_ERR1;
      default:     return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// Priority address decoder. Index 0 has the highest priority; isolated (hung)
// subordinates never match.
//   addr : master HADDR        pma  : per-subordinate base/mask
//   hung : isolation flags     hsel : one-hot (or zero) select
//   idx  : winning index       hit  : any subordinate matched
module ahb_addr_decoder
  import ahb_interconnect_guard_pkg::*;
#(
  parameter int SLAVES = 4,
  parameter int IW     = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic [31:0]                addr,
  input  pma_cfg_t [SLAVES-1:0]      pma,
  input  logic [SLAVES-1:0]          hung,
  output logic [SLAVES-1:0]          hsel,
  output logic [IW-1:0]              idx,
  output logic                       hit
);

  logic [SLAVES-1:0] match;

  for (genvar g = 0; g < SLAVES; g++) begin : g_match
    assign match[g] = ((addr & pma[g].mask) == pma[g].base) & ~hung[g];
  end

  // Isolate the lowest set bit: that is the highest-priority match.
  assign hsel = match & (~match + 1'b1);
  assign hit  = |match;

  always_comb begin
    idx = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (match[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/ahb_interconnect_guard.sv
// AHB3-Lite single-master decoder / response mux with a default ERROR
// subordinate, a per-data-phase hready watchdog and sticky isolation of
// subordinates that time out.
//   s_clk_i / s_resetn_i          : clock, async active-low reset
//   s_mhaddr_i / s_mhtrans_i      : master address phase
//   s_sbase_i / s_smask_i         : region map per subordinate
//   s_shrdata_i .. s_shresp_i     : subordinate data-phase responses
//   s_hsel_o                      : one-hot select (address phase)
//   s_shrdata_o .. s_shresp_o     : muxed response to master (s_shready_o also to subordinates)
//   s_timeout_o                   : one-cycle pulse on watchdog abort
//   s_hung_o                      : sticky isolation flag per subordinate
module ahb_interconnect_guard
  import ahb_interconnect_guard_pkg::*;
#(
  parameter int SLAVES  = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                     s_clk_i,
  input  logic                     s_resetn_i,
  input  logic [31:0]              s_mhaddr_i,
  input  logic [1:0]               s_mhtrans_i,
  input  logic [SLAVES-1:0][31:0]  s_sbase_i,
  input  logic [SLAVES-1:0][31:0]  s_smask_i,
  input  logic [SLAVES-1:0][31:0]  s_shrdata_i,
  input  logic [SLAVES-1:0][6:0]   s_shrchecksum_i,
  input  logic [SLAVES-1:0]        s_shready_i,
  input  logic [SLAVES-1:0]        s_shresp_i,
  output logic [SLAVES-1:0]        s_hsel_o,
  output logic [31:0]              s_shrdata_o,
  output logic [6:0]               s_shrchecksum_o,
  output logic                     s_shready_o,
  output logic                     s_shresp_o,
  output logic                     s_timeout_o,
  output logic [SLAVES-1:0]        s_hung_o
);

  localparam int IW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  pma_cfg_t [SLAVES-1:0] pma;
  logic [IW-1:0]         dec_idx;
  logic                  dec_hit;

  state_e                state;
  logic [IW-1:0]         owner_idx;
  logic [CW-1:0]         wait_cnt;
  logic [SLAVES-1:0]     hung;
  logic                  timeout_q;

  owner_t                acc_owner;
  logic                  owner_ready;
  logic                  limit_hit;

  for (genvar g = 0; g < SLAVES; g++) begin : g_pma
    assign pma[g].base = s_sbase_i[g];
    assign pma[g].mask = s_smask_i[g];
  end

  ahb_addr_decoder #(.SLAVES(SLAVES), .IW(IW)) u_dec (
    .addr (s_mhaddr_i),
    .pma  (pma),
    .hung (hung),
    .hsel (s_hsel_o),
    .idx  (dec_idx),
    .hit  (dec_hit)
  );

  assign owner_ready = s_shready_i[owner_idx];
  assign limit_hit   = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));
  assign acc_owner   = !is_active(s_mhtrans_i) ? OWN_NONE :
                       dec_hit ? OWN_SLAVE : OWN_DEFAULT;

  // Response mux: state is async-reset, so a reset returns these to the
  // idle values immediately without issuing an ERROR.
  always_comb begin
    s_shrdata_o     = '0;
    s_shrchecksum_o = '0;
    s_shready_o     = 1'b1;
    s_shresp_o      = 1'b0;
    case (state)
      ST_SLAVE: begin
        s_shrdata_o     = s_shrdata_i[owner_idx];
        s_shrchecksum_o = s_shrchecksum_i[owner_idx];
        s_shready_o     = owner_ready;
        s_shresp_o      = s_shresp_i[owner_idx];
      end
      ST_ERR1: begin
        s_shready_o = 1'b0;
        s_shresp_o  = 1'b1;
      end
      ST_ERR2:  s_shresp_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state     <= ST_IDLE;
      owner_idx <= '0;
      wait_cnt  <= '0;
      hung      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR2: begin
          state     <= owner_state(acc_owner);
          owner_idx <= dec_idx;
          wait_cnt  <= '0;
        end
        ST_SLAVE: begin
          // A completing subordinate wins over a coincident watchdog limit.
          if (owner_ready) begin
            state     <= owner_state(acc_owner);
            owner_idx <= dec_idx;
            wait_cnt  <= '0;
          end else if (limit_hit) begin
            hung[owner_idx] <= 1'b1;
            timeout_q       <= 1'b1;
            state           <= ST_ERR1;
            wait_cnt        <= '0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_ERR1: state <= ST_ERR2;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_timeout_o = timeout_q;
  assign s_hung_o    = hung;

endmodule

// File: tb/tb_ahb_interconnect_guard.sv
module tb_ahb_interconnect_guard;
  localparam int NS = 3;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [31:0]          haddr;
  logic [1:0]           htrans;
  logic [NS-1:0][31:0]  sbase, smask, shrdata;
  logic [NS-1:0][6:0]   shcks;
  logic [NS-1:0]        shready, shresp;
  logic [NS-1:0]        hsel, hung;
  logic [31:0]          rdata;
  logic [6:0]           cks;
  logic                 hready, hresp, tout;

  ahb_interconnect_guard #(.SLAVES(NS), .TIMEOUT(TO)) dut (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_mhaddr_i(haddr), .s_mhtrans_i(htrans),
    .s_sbase_i(sbase), .s_smask_i(smask), .s_shrdata_i(shrdata),
    .s_shrchecksum_i(shcks), .s_shready_i(shready), .s_shresp_i(shresp),
    .s_hsel_o(hsel), .s_shrdata_o(rdata), .s_shrchecksum_o(cks),
    .s_shready_o(hready), .s_shresp_o(hresp), .s_timeout_o(tout), .s_hung_o(hung)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic cfg_default();
    sbase[0] = 32'h1000_0000; smask[0] = 32'hF000_0000;
    sbase[1] = 32'h8000_0000; smask[1] = 32'hFFFF_F000;
    sbase[2] = 32'h8000_1000; smask[2] = 32'hFFFF_F000;
  endtask

  // Reference decode straight from the region rule: lowest matching, non-hung index.
  function automatic int ref_dec(input logic [31:0] a, input logic [NS-1:0] hg);
    for (int i = 0; i < NS; i++)
      if (((a & smask[i]) == sbase[i]) && !hg[i]) return i;
    return -1;
  endfunction

  typedef struct {
    logic [31:0]   addr;
    logic [1:0]    trans;
    logic [NS-1:0] exp_hsel;
  } dec_vec_t;

  dec_vec_t dvec [10];

  // Transfer-level reference model state.
  int            m_own;    // data-phase owner index, -1 when none
  int            m_err;    // error cycles remaining: 2 = first, 1 = second
  int            m_waits;  // wait cycles seen in the current data phase
  logic [NS-1:0] m_hung;
  logic          m_to;
  int            stall_left [NS];

  task automatic model_reset();
    m_own = -1; m_err = 0; m_waits = 0; m_hung = '0; m_to = 1'b0;
  endtask

  initial begin
    logic          e_rdy, e_rsp;
    logic [31:0]   e_rd;
    logic [6:0]    e_ck;
    int            d;
    logic [NS-1:0] e_hsel;
    logic          nto;

    dvec[0] = '{32'h1000_0000, 2'b10, 3'b001};
    dvec[1] = '{32'h1FFF_FFFC, 2'b00, 3'b001};
    dvec[2] = '{32'h8000_0000, 2'b11, 3'b010};
    dvec[3] = '{32'h8000_0FFC, 2'b01, 3'b010};
    dvec[4] = '{32'h8000_1000, 2'b10, 3'b100};
    dvec[5] = '{32'h8000_1004, 2'b00, 3'b100};
    dvec[6] = '{32'h8000_2000, 2'b10, 3'b000};
    dvec[7] = '{32'h4000_0000, 2'b10, 3'b000};
    dvec[8] = '{32'h0000_0000, 2'b11, 3'b000};
    dvec[9] = '{32'h2000_0000, 2'b00, 3'b000};

    cfg_default();
    shready = '1; shresp = '0;
    shrdata = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    shcks   = {7'h22, 7'h11, 7'h05};
    haddr = '0; htrans = 2'b00; rst_n = 1'b0;
    #12;
    cmp("rst_hready", hready, 1'b1);
    cmp("rst_hresp",  hresp,  1'b0);
    cmp("rst_rdata",  rdata,  32'h0);
    cmp("rst_timeout", tout,  1'b0);
    cmp("rst_hung",   hung,   3'b000);
    rst_n = 1'b1;
    tick();

    // Decode table: hsel depends only on address and region map.
    foreach (dvec[k]) begin
      haddr = dvec[k].addr; htrans = dvec[k].trans;
      #1;
      cmp($sformatf("dec_tbl%0d", k), hsel, dvec[k].exp_hsel);
    end
    htrans = 2'b00;
    tick();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();

    // Read from subordinate 2.
    haddr = 32'h8000_1004; htrans = 2'b10; settle();
    cmp("t1_hsel", hsel, 3'b100);
    tick(); htrans = 2'b00; haddr = '0; settle();
    cmp("t1_rdata",  rdata, 32'hC0DE_0002);
    cmp("t1_cks",    cks,   7'h22);
    cmp("t1_hready", hready, 1'b1);
    cmp("t1_hresp",  hresp,  1'b0);

    // Unmapped access gets the two-cycle default ERROR.
    haddr = 32'h4000_0000; htrans = 2'b10; settle();
    cmp("t2_hsel", hsel, 3'b000);
    tick(); htrans = 2'b00; settle();
    cmp("t2_err1_hready", hready, 1'b0);
    cmp("t2_err1_hresp",  hresp,  1'b1);
    tick();
    cmp("t2_err2_hready", hready, 1'b1);
    cmp("t2_err2_hresp",  hresp,  1'b1);
    tick();
    cmp("t2_idle_hready", hready, 1'b1);
    cmp("t2_idle_hresp",  hresp,  1'b0);
    cmp("t2_idle_rdata",  rdata,  32'h0);

    // Overlapping regions: index 0 wins.
    sbase[1] = 32'h1000_0000; smask[1] = 32'hF000_0000;
    haddr = 32'h1000_0040; settle();
    cmp("t3_overlap_hsel", hsel, 3'b001);
    cfg_default();

    // Watchdog abort on subordinate 1.
    haddr = 32'h8000_0010; htrans = 2'b10; settle();
    cmp("t4_hsel", hsel, 3'b010);
    tick(); htrans = 2'b00; shready[1] = 1'b0;
    for (int k = 0; k < TO; k++) begin
      settle();
      cmp($sformatf("t4_wait%0d_hready", k), hready, 1'b0);
      cmp($sformatf("t4_wait%0d_timeout", k), tout, 1'b0);
      tick();
    end
    settle();
    cmp("t4_timeout_pulse", tout, 1'b1);
    cmp("t4_hung", hung, 3'b010);
    cmp("t4_err1_hready", hready, 1'b0);
    cmp("t4_err1_hresp",  hresp,  1'b1);
    tick();
    haddr = 32'h8000_0010; htrans = 2'b10; settle();
    cmp("t4_reaccess_hsel", hsel, 3'b000);
    cmp("t4_err2_hready", hready, 1'b1);
    cmp("t4_err2_hresp",  hresp,  1'b1);
    cmp("t4_pulse_end",   tout,   1'b0);
    tick(); htrans = 2'b00; shready[1] = 1'b1; settle();
    cmp("t4_reaccess_err_hready", hready, 1'b0);
    cmp("t4_reaccess_err_hresp",  hresp,  1'b1);
    cmp("t4_hung_sticky", hung, 3'b010);

    // Async reset while in the first error cycle.
    rst_n = 1'b0; #1;
    cmp("t6_rst_hready", hready, 1'b1);
    cmp("t6_rst_hresp",  hresp,  1'b0);
    cmp("t6_rst_hung",   hung,   3'b000);
    rst_n = 1'b1;
    tick();
    haddr = 32'h8000_0010; htrans = 2'b10; settle();
    cmp("t6_hsel", hsel, 3'b010);
    tick(); htrans = 2'b00; settle();
    cmp("t6_rdata",  rdata,  32'hC0DE_0001);
    cmp("t6_hready", hready, 1'b1);
    cmp("t6_hresp",  hresp,  1'b0);

    // Subordinate 0 completes on the last allowed wait cycle: no abort.
    haddr = 32'h1000_0000; htrans = 2'b10;
    tick(); htrans = 2'b00; shready[0] = 1'b0;
    for (int k = 0; k < TO - 1; k++) begin
      settle();
      cmp($sformatf("t5_wait%0d_hready", k), hready, 1'b0);
      tick();
    end
    shready[0] = 1'b1; settle();
    cmp("t5_done_hready", hready, 1'b1);
    cmp("t5_done_hresp",  hresp,  1'b0);
    cmp("t5_done_rdata",  rdata,  32'hC0DE_0000);
    tick(); settle();
    cmp("t5_no_pulse", tout, 1'b0);
    cmp("t5_no_hung",  hung, 3'b000);
    cmp("t5_idle_hready", hready, 1'b1);

    // Randomized traffic against the transfer-level model.
    tick();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_reset();
    foreach (stall_left[i]) stall_left[i] = 0;
    tick();
    for (int cyc = 0; cyc < 1200; cyc++) begin
      case ($urandom_range(0, 4))
        0: haddr = 32'h1000_0000 | ($urandom() & 32'h0FFF_FFFC);
        1: haddr = 32'h8000_0000 | ($urandom() & 32'h0000_0FFC);
        2: haddr = 32'h8000_1000 | ($urandom() & 32'h0000_0FFC);
        3: haddr = 32'h4000_0000 | ($urandom() & 32'h00FF_FFFC);
        default: haddr = $urandom();
      endcase
      htrans = 2'($urandom_range(0, 3));
      for (int i = 0; i < NS; i++) begin
        shrdata[i] = $urandom();
        shcks[i]   = 7'($urandom());
        shresp[i]  = ($urandom_range(0, 7) == 0);
        if (stall_left[i] > 0) begin
          shready[i] = 1'b0;
          stall_left[i]--;
        end else begin
          shready[i] = 1'b1;
          if ($urandom_range(0, 24) == 0) stall_left[i] = $urandom_range(1, 12);
        end
      end
      if (cyc % 300 == 299) begin
        rst_n = 1'b0; #1;
        cmp("rnd_rst_hready", hready, 1'b1);
        cmp("rnd_rst_hung",   hung,   3'b000);
        rst_n = 1'b1;
        model_reset();
      end
      settle();

      if (m_err == 2) begin
        e_rdy = 1'b0; e_rsp = 1'b1; e_rd = '0; e_ck = '0;
      end else if (m_err == 1) begin
        e_rdy = 1'b1; e_rsp = 1'b1; e_rd = '0; e_ck = '0;
      end else if (m_own >= 0) begin
        e_rdy = shready[m_own]; e_rsp = shresp[m_own];
        e_rd = shrdata[m_own];  e_ck = shcks[m_own];
      end else begin
        e_rdy = 1'b1; e_rsp = 1'b0; e_rd = '0; e_ck = '0;
      end
      d = ref_dec(haddr, m_hung);
      e_hsel = (d >= 0) ? NS'(1 << d) : '0;

      cmp("rnd_hready", hready, e_rdy);
      cmp("rnd_hresp",  hresp,  e_rsp);
      cmp("rnd_rdata",  rdata,  e_rd);
      cmp("rnd_cks",    cks,    e_ck);
      cmp("rnd_hsel",   hsel,   e_hsel);
      cmp("rnd_timeout", tout,  m_to);
      cmp("rnd_hung",   hung,   m_hung);

      nto = 1'b0;
      if (m_err == 2) begin
        m_err = 1;
      end else if (!e_rdy) begin
        m_waits++;
        if (m_waits == TO) begin
          m_hung[m_own] = 1'b1;
          nto = 1'b1; m_err = 2; m_own = -1;
        end
      end else begin
        m_err = 0; m_waits = 0; m_own = -1;
        if (htrans[1]) begin
          if (d >= 0) m_own = d;
          else        m_err = 2;
        end
      end
      m_to = nto;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
